// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, state
// encoding and datapath mux/ALU select codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MADDR  = 4'd3,
    ST_MRD    = 4'd4,
    ST_MWB    = 4'd5,
    ST_MWR    = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_AEX    = 4'd9,
    ST_AWB    = 4'd10,
    ST_BR     = 4'd11,
    ST_JMP    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // States that hold on the memory ready handshake and are watched by the timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MRD) || (s == ST_MWR);
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Saturating wait-cycle counter for the memory handshake watchdog.
// TIMEOUT of 0 keeps expired_o low permanently.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned CNT_W = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins, otherwise count up to LIMIT and hold there
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT != 32'd0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM: FETCH/DECODE then a per-class path,
// with a watchdog on every memory wait.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned ALUOP_W  = 2,
  parameter bit          EN_BNE   = 1'b1,
  parameter bit          EN_ADDI  = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_wr_eq,
  output logic                pc_wr_ne,
  output logic [1:0]          pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                instr_done,
  output logic                illegal_op,
  output logic                mem_timeout
);

  state_e state_q, state_d;
  logic   is_bne_q, is_bne_d;
  logic   is_lw_q, is_lw_d;
  logic   mem_timeout_q, mem_timeout_d;
  state_e dec_target_s;
  logic   waiting_s, expired_s, abort_s, tmr_en_s, tmr_clear_s;

  // Successor of DECODE; FETCH marks an unsupported opcode.
  function automatic state_e decode_target(input logic [OPCODE_W-1:0] op);
    state_e t;
    case (op)
      OPCODE_W'(OP_LW),
      OPCODE_W'(OP_SW):    t = ST_MADDR;
      OPCODE_W'(OP_RTYPE): t = ST_EXEC;
      OPCODE_W'(OP_ADDI):  t = EN_ADDI ? ST_AEX : ST_FETCH;
      OPCODE_W'(OP_BEQ):   t = ST_BR;
      OPCODE_W'(OP_BNE):   t = EN_BNE ? ST_BR : ST_FETCH;
      OPCODE_W'(OP_J):     t = ST_JMP;
      default:             t = ST_FETCH;
    endcase
    return t;
  endfunction

  assign dec_target_s = decode_target(opcode);
  assign waiting_s    = is_wait_state(state_q);
  assign tmr_en_s     = waiting_s && !mem_ready;
  assign abort_s      = tmr_en_s && expired_s;
  // the counter only survives a cycle that keeps stalling in the same wait
  assign tmr_clear_s  = !tmr_en_s || abort_s;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (tmr_clear_s),
    .en_i     (tmr_en_s),
    .expired_o(expired_s)
  );

  // state, decode latches and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RST;
      is_bne_q      <= 1'b0;
      is_lw_q       <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      is_bne_q      <= is_bne_d;
      is_lw_q       <= is_lw_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d       = state_q;
    is_bne_d      = is_bne_q;
    is_lw_d       = is_lw_q;
    mem_timeout_d = mem_timeout_q | abort_s;
    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        is_bne_d = (opcode == OPCODE_W'(OP_BNE));
        is_lw_d  = (opcode == OPCODE_W'(OP_LW));
        state_d  = dec_target_s;
      end
      ST_MADDR: begin
        if (is_lw_q) begin
          state_d = ST_MRD;
        end else begin
          state_d = ST_MWR;
        end
      end
      ST_MRD: begin
        if (mem_ready) begin
          state_d = ST_MWB;
        end else if (abort_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MRD;
        end
      end
      ST_MWR: begin
        if (mem_ready || abort_s) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MWR;
        end
      end
      ST_EXEC: state_d = ST_RWB;
      ST_AEX:  state_d = ST_AWB;
      ST_MWB, ST_RWB, ST_AWB, ST_BR, ST_JMP: state_d = ST_FETCH;
      default: state_d = ST_RST;
    endcase
  end

  // Moore output decode; FETCH load enables and the MWR done pulse follow mem_ready
  always_comb begin
    pc_write   = 1'b0;
    pc_wr_eq   = 1'b0;
    pc_wr_ne   = 1'b0;
    pc_source  = PCSRC_ALU;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    aluop      = ALUOP_W'(ALUOP_ADD);
    instr_done = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = (dec_target_s == ST_FETCH);
      end
      ST_MADDR, ST_AEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      ST_MWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_W'(ALUOP_FUNCT);
      end
      ST_RWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      ST_AWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      ST_BR: begin
        alu_src_a  = 1'b1;
        aluop      = ALUOP_W'(ALUOP_SUB);
        pc_source  = PCSRC_ALUOUT;
        pc_wr_eq   = !is_bne_q;
        pc_wr_ne   = is_bne_q;
        instr_done = 1'b1;
      end
      ST_JMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
  end

  assign mem_timeout = mem_timeout_q;

endmodule
